seq_compare: RTL and testbench

SEQ_COMPARE -- requirements
Module: seq_compare

---
 rtl/seq_compare.sv | 149 ++++++++++++++
 tb/tb_seq_compare.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_compare.sv
// Streaming X/Y comparator with IDLE/RUN/TRIP run control, saturating counters and valid/ready handshakes.
// Define CMP_CAPTURE_EN to add cap_x/cap_y/cap_idx, which latch the pair that first tripped the run.
module seq_compare #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             signed_cmp,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             busy,
  output logic             tripped
`ifdef CMP_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] cap_x,
  output logic [WIDTH-1:0] cap_y,
  output logic [CNT_W-1:0] cap_idx
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, TRIP} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             result_q, result_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] mismatch_q, mismatch_d;
  logic             accept;
  logic             differ;
  logic             cmp_bit;
  logic             arm;

  assign differ = (X != Y);
  assign accept = in_valid & in_ready;
  // Stop beats start, so a simultaneous start/stop in IDLE neither arms nor clears.
  assign arm    = (state_q == IDLE) & start & ~stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arm) state_d = RUN;
      RUN: begin
        if (stop)                 state_d = IDLE;
        else if (accept && differ) state_d = TRIP;
      end
      TRIP: if (stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    tripped  = (state_q == TRIP);
    in_ready = busy & (~out_valid_q | out_ready);
  end

  always_comb begin
    cmp_bit = 1'b0;
    case (mode)
      2'b00: cmp_bit = differ;
      2'b01: cmp_bit = ~differ;
      2'b10: cmp_bit = signed_cmp ? ($signed(X) < $signed(Y)) : (X < Y);
      2'b11: cmp_bit = signed_cmp ? ($signed(X) > $signed(Y)) : (X > Y);
      default: cmp_bit = 1'b0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sample_d    = sample_q;
    mismatch_d  = mismatch_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = cmp_bit;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (arm) begin
      sample_d   = '0;
      mismatch_d = '0;
    end else if (accept) begin
      if (sample_q != {CNT_W{1'b1}})               sample_d   = sample_q + CNT_W'(1);
      if (differ && mismatch_q != {CNT_W{1'b1}})   mismatch_d = mismatch_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= 1'b0;
      sample_q    <= '0;
      mismatch_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sample_q    <= sample_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign sample_cnt   = sample_q;
  assign mismatch_cnt = mismatch_q;

`ifdef CMP_CAPTURE_EN
  logic [WIDTH-1:0] cap_x_q, cap_y_q;
  logic [CNT_W-1:0] cap_idx_q;

  // Index is the pre-increment sample count, i.e. the zero-based position of the tripping pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_x_q   <= '0;
      cap_y_q   <= '0;
      cap_idx_q <= '0;
    end else if (arm) begin
      cap_x_q   <= '0;
      cap_y_q   <= '0;
      cap_idx_q <= '0;
    end else if (state_q == RUN && state_d == TRIP) begin
      cap_x_q   <= X;
      cap_y_q   <= Y;
      cap_idx_q <= sample_q;
    end
  end

  assign cap_x   = cap_x_q;
  assign cap_y   = cap_y_q;
  assign cap_idx = cap_idx_q;
`endif

endmodule

// File: tb/tb_seq_compare.sv
// Self-checking bench for seq_compare: per-scenario tasks plus a result scoreboard.
module tb_seq_compare;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop;
  logic [1:0] mode;
  logic       signed_cmp;
  logic       in_valid, in_ready;
  logic [7:0] X, Y;
  logic       out_valid, out_ready, result;
  logic [3:0] sample_cnt, mismatch_cnt;
  logic       busy, tripped;
`ifdef CMP_CAPTURE_EN
  logic [7:0] cap_x, cap_y;
  logic [3:0] cap_idx;
`endif

  int checks = 0;
  int errors = 0;
  bit expQ[$];

  seq_compare #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .signed_cmp(signed_cmp), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt), .busy(busy), .tripped(tripped)
`ifdef CMP_CAPTURE_EN
    , .cap_x(cap_x), .cap_y(cap_y), .cap_idx(cap_idx)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit model(input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] m, input logic s);
    case (m)
      2'b00: return a != b;
      2'b01: return a == b;
      2'b10: return s ? ($signed(a) < $signed(b)) : (a < b);
      default: return s ? ($signed(a) > $signed(b)) : (a > b);
    endcase
  endfunction

  // Scoreboard: pop on the delivering handshake first, then push what the next edge accepts.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_unexpected: got result %0b, required no output", result);
      end else begin
        bit e;
        e = expQ.pop_front();
        if (result !== e) begin
          errors++;
          $display("[TB] FAIL scoreboard_result: got %0b, required %0b", result, e);
        end
      end
    end
    if (rst_n && in_valid && in_ready) expQ.push_back(model(X, Y, mode, signed_cmp));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; mode = 0; signed_cmp = 0;
    in_valid = 0; X = 0; Y = 0; out_ready = 1;
    step(); step();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tripped", tripped, 0);
    chk("reset_counts", {sample_cnt, mismatch_cnt}, 0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    pulseStart();
    chk("basic_busy", busy, 1);
    chk("basic_in_ready", in_ready, 1);
    mode = 2'b00; in_valid = 1; X = 8'h12; Y = 8'h12;
    step();
    chk("basic_res0", result, 0);
    chk("basic_tripped0", tripped, 0);
    Y = 8'h13;
    step();
    in_valid = 0;
    chk("basic_res1", result, 1);
    chk("basic_tripped1", tripped, 1);
    chk("basic_mismatch", mismatch_cnt, 1);
    chk("basic_sample", sample_cnt, 2);
`ifdef CMP_CAPTURE_EN
    chk("basic_cap_idx", cap_idx, 1);
    chk("basic_cap_x", cap_x, 8'h12);
    chk("basic_cap_y", cap_y, 8'h13);
`endif
    step();
    chk("basic_out_valid_clear", out_valid, 0);
  endtask

  task automatic test_signed();
    mode = 2'b10; X = 8'h80; Y = 8'h01; signed_cmp = 0; in_valid = 1;
    step();
    chk("unsigned_lt", result, 0);
    signed_cmp = 1;
    step();
    chk("signed_lt", result, 1);
    mode = 2'b11;
    step();
    chk("signed_gt", result, 0);
    signed_cmp = 0;
    step();
    in_valid = 0;
    chk("unsigned_gt", result, 1);
    step();
  endtask

  task automatic test_backpressure();
    logic [3:0] s;
    mode = 2'b01; X = 8'h05; Y = 8'h05; out_ready = 0; in_valid = 1;
    s = sample_cnt;
    step();
    chk("bp_first_result", result, 1);
    chk("bp_in_ready_low", in_ready, 0);
    X = 8'h07;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", result, 1);
      chk("bp_hold_count", sample_cnt, s + 4'd1);
    end
    out_ready = 1;
    #1;
    chk("bp_in_ready_back", in_ready, 1);
    step();
    in_valid = 0;
    chk("bp_second_result", result, 0);
    chk("bp_count_after", sample_cnt, s + 4'd2);
    step();
  endtask

  task automatic test_saturation();
    stop = 1; step(); stop = 0;
    pulseStart();
    chk("sat_cleared", {sample_cnt, mismatch_cnt}, 0);
    mode = 2'b00; in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      X = 8'(i); Y = 8'(i + 1);
      step();
    end
    in_valid = 0;
    chk("sat_sample", sample_cnt, 15);
    chk("sat_mismatch", mismatch_cnt, 15);
    chk("sat_tripped", tripped, 1);
    step();
  endtask

  task automatic test_start_stop();
    stop = 1; step(); stop = 0;
    chk("stop_idle", busy, 0);
    chk("stop_hold_sample", sample_cnt, 15);
    chk("stop_hold_mismatch", mismatch_cnt, 15);
    start = 1; stop = 1; in_valid = 1;
    step();
    start = 0; stop = 0;
    chk("startstop_busy", busy, 0);
    chk("startstop_in_ready", in_ready, 0);
    step();
    in_valid = 0;
    chk("startstop_no_accept", out_valid, 0);
  endtask

  task automatic test_stop_with_accept();
    pulseStart();
    out_ready = 0; in_valid = 1; mode = 2'b00; X = 8'h3; Y = 8'h4; stop = 1;
    step();
    stop = 0; in_valid = 0;
    chk("sa_idle", busy, 0);
    chk("sa_out_valid", out_valid, 1);
    chk("sa_sample", sample_cnt, 1);
    chk("sa_mismatch", mismatch_cnt, 1);
    step(); step();
    chk("sa_pending", out_valid, 1);
    out_ready = 1;
    step();
    chk("sa_consumed", out_valid, 0);
  endtask

  task automatic test_reset_midrun();
    pulseStart();
    out_ready = 0; in_valid = 1; mode = 2'b00; X = 8'h1; Y = 8'h2;
    step();
    in_valid = 0;
    chk("mr_pre_valid", out_valid, 1);
    chk("mr_pre_tripped", tripped, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_counts", {sample_cnt, mismatch_cnt}, 0);
    chk("mr_tripped", tripped, 0);
    chk("mr_busy", busy, 0);
    expQ.delete();
    step();
    rst_n = 1'b1; out_ready = 1;
    step();
    chk("mr_resume_idle", busy, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_saturation();
    test_start_stop();
    test_stop_with_accept();
    test_reset_midrun();
    step();
    chk("scoreboard_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, required finish");
    $fatal(1);
  end

endmodule
